alu_result_stage: RTL and testbench

Registered output stage directly downstream of the combinational shift/ALU operation units.
- Captures each result (K bits) and its 4-bit status word.
- Buffers results in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Keeps sticky status flags and a transaction counter for the control/debug logic.
- Lets the combinational ALU path be cut by a register and stalled by the consumer without losing results.

---
 rtl/alu_result_stage.sv | 158 +++++++++++++++
 tb/tb_alu_result_stage.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered 2-entry skid buffer behind the shift/ALU
// operation units. Holds each K-bit result and its 4-bit status word, keeps
// sticky status flags and an accepted-transaction counter.
// Optional build macro ALU_RESULT_ERR_CNT_EN adds a saturating error-event
// counter on o_err_cnt. When the macro is undefined, o_err_cnt is tied to 0.
module alu_result_stage #(
   parameter int K     = 8,
   parameter int CNT_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [K-1:0]     i_result,
   input  logic [3:0]       i_status,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [K-1:0]     o_result,
   output logic [3:0]       o_status,
   output logic [3:0]       o_sticky,
   input  logic             i_clear_sticky,
   output logic [CNT_W-1:0] o_txn_cnt,
   output logic [7:0]       o_err_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state_q;
   state_t           state_d;

   logic             accept;
   logic             pop;
   logic             load_head_in;
   logic             load_head_skid;
   logic             load_skid_in;

   logic [K-1:0]     head_result_p1;
   logic [3:0]       head_status_p1;
   logic [K-1:0]     skid_result_p1;
   logic [3:0]       skid_status_p1;

   logic [3:0]       sticky_q;
   logic [CNT_W-1:0] txn_cnt_q;

   // Increment that wraps naturally at 2^CNT_W.
   function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] v);
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
   endfunction

   // State register: number of entries held.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state_q <= EMPTY;
      else          state_q <= state_d;
   end

   // Next-state logic from the accept/pop pair seen on this edge.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = ONE;
         ONE: begin
            if (accept && !pop)      state_d = FULL;
            else if (!accept && pop) state_d = EMPTY;
         end
         FULL: if (pop) state_d = ONE;
         default: state_d = EMPTY;
      endcase
   end

   // Output and datapath-control decode; depends only on state plus handshakes.
   always_comb begin
      o_valid        = (state_q != EMPTY);
      o_ready        = (state_q != FULL);
      accept         = i_valid & o_ready;
      pop            = o_valid & i_ready;
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid_in   = 1'b0;
      case (state_q)
         EMPTY: load_head_in = accept;
         ONE: begin
            load_head_in = accept & pop;
            load_skid_in = accept & ~pop;
         end
         FULL: load_head_skid = pop;
         default: ;
      endcase
   end

   // Head entry: loaded from the input or promoted from the skid entry.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         head_result_p1 <= '0;
         head_status_p1 <= '0;
      end else if (load_head_in) begin
         head_result_p1 <= i_result;
         head_status_p1 <= i_status;
      end else if (load_head_skid) begin
         head_result_p1 <= skid_result_p1;
         head_status_p1 <= skid_status_p1;
      end
   end

   // Skid entry: catches the second result while the consumer stalls.
   always_ff @(posedge i_clk) begin
      if (load_skid_in) begin
         skid_result_p1 <= i_result;
         skid_status_p1 <= i_status;
      end
   end

   assign o_result = head_result_p1;
   assign o_status = head_status_p1;

   // Sticky flags: clear takes effect first so a coincident accept survives.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) sticky_q <= '0;
      else          sticky_q <= (i_clear_sticky ? 4'b0000 : sticky_q)
                                | (accept ? i_status : 4'b0000);
   end

   // Accepted-transaction counter; not affected by the sticky clear.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)    txn_cnt_q <= '0;
      else if (accept) txn_cnt_q <= wrap_inc(txn_cnt_q);
   end

   assign o_sticky  = sticky_q;
   assign o_txn_cnt = txn_cnt_q;

`ifdef ALU_RESULT_ERR_CNT_EN
   logic [7:0] err_cnt_q;
   logic       err_event;

   // Saturating increment: holds at 255.
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign err_event = accept & (i_status[0] | i_status[3]);

   // Error counter: clear to zero, then count a coincident error accept.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n)            err_cnt_q <= '0;
      else if (i_clear_sticky) err_cnt_q <= err_event ? 8'd1 : 8'd0;
      else if (err_event)      err_cnt_q <= sat_inc(err_cnt_q);
   end

   assign o_err_cnt = err_cnt_q;
`else
   assign o_err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Testbench for alu_result_stage: table of per-cycle vectors with
// hand-computed expectations, plus streaming and error-counter sequences.
module tb_alu_result_stage;

   localparam int K     = 8;
   localparam int CNT_W = 16;
`ifdef ALU_RESULT_ERR_CNT_EN
   localparam int EN = 1;
`else
   localparam int EN = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid_in;
   logic             ready_out;
   logic [K-1:0]     result_in;
   logic [3:0]       status_in;
   logic             valid_out;
   logic             ready_in;
   logic [K-1:0]     result_out;
   logic [3:0]       status_out;
   logic [3:0]       sticky;
   logic             clear_sticky;
   logic [CNT_W-1:0] txn_cnt;
   logic [7:0]       err_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_result_stage #(.K(K), .CNT_W(CNT_W)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .i_valid        (valid_in),
      .o_ready        (ready_out),
      .i_result       (result_in),
      .i_status       (status_in),
      .o_valid        (valid_out),
      .i_ready        (ready_in),
      .o_result       (result_out),
      .o_status       (status_out),
      .o_sticky       (sticky),
      .i_clear_sticky (clear_sticky),
      .o_txn_cnt      (txn_cnt),
      .o_err_cnt      (err_cnt)
   );

   typedef struct {
      logic       rst_n;
      logic       v;
      logic [7:0] res;
      logic [3:0] st;
      logic       rdy;
      logic       clr;
      logic       e_v;
      logic       e_rdy;
      logic [7:0] e_res;
      logic [3:0] e_st;
      logic [3:0] e_sticky;
      int         e_cnt;
      int         e_err;
   } vec_t;

   vec_t vecs[17];

   task automatic chk(input string name, input int idx, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [7:0] res,
                        input logic [3:0] st, input logic rdy, input logic clr);
      rst_n = r; valid_in = v; result_in = res; status_in = st;
      ready_in = rdy; clear_sticky = clr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          rst v  res    st       rdy clr | ov  ordy eres  est      esticky  cnt err
      vecs[0]  = '{0, 0, 8'h00, 4'b0000, 0, 0,   0, 1, 8'h00, 4'b0000, 4'b0000, 0, 0};
      vecs[1]  = '{1, 1, 8'h0F, 4'b0010, 1, 0,   1, 1, 8'h0F, 4'b0010, 4'b0010, 1, 0};
      vecs[2]  = '{1, 0, 8'h00, 4'b0000, 1, 0,   0, 1, 8'h0F, 4'b0010, 4'b0010, 1, 0};
      vecs[3]  = '{0, 0, 8'h00, 4'b0000, 0, 0,   0, 1, 8'h00, 4'b0000, 4'b0000, 0, 0};
      vecs[4]  = '{1, 1, 8'h01, 4'b0000, 0, 0,   1, 1, 8'h01, 4'b0000, 4'b0000, 1, 0};
      vecs[5]  = '{1, 1, 8'h02, 4'b0000, 0, 0,   1, 0, 8'h01, 4'b0000, 4'b0000, 2, 0};
      vecs[6]  = '{1, 1, 8'h03, 4'b0000, 0, 0,   1, 0, 8'h01, 4'b0000, 4'b0000, 2, 0};
      vecs[7]  = '{1, 1, 8'h03, 4'b0000, 1, 0,   1, 1, 8'h02, 4'b0000, 4'b0000, 2, 0};
      vecs[8]  = '{1, 1, 8'h03, 4'b0000, 1, 0,   1, 1, 8'h03, 4'b0000, 4'b0000, 3, 0};
      vecs[9]  = '{1, 0, 8'h00, 4'b0000, 1, 0,   0, 1, 8'h03, 4'b0000, 4'b0000, 3, 0};
      vecs[10] = '{1, 1, 8'hAA, 4'b1000, 1, 0,   1, 1, 8'hAA, 4'b1000, 4'b1000, 4, 1};
      vecs[11] = '{1, 1, 8'hBB, 4'b0100, 1, 0,   1, 1, 8'hBB, 4'b0100, 4'b1100, 5, 1};
      vecs[12] = '{1, 1, 8'hCC, 4'b0001, 1, 1,   1, 1, 8'hCC, 4'b0001, 4'b0001, 6, 1};
      vecs[13] = '{1, 0, 8'h00, 4'b0000, 0, 1,   1, 1, 8'hCC, 4'b0001, 4'b0000, 6, 0};
      vecs[14] = '{1, 1, 8'hDD, 4'b0010, 0, 0,   1, 0, 8'hCC, 4'b0001, 4'b0010, 7, 0};
      vecs[15] = '{0, 1, 8'hEE, 4'b1111, 0, 0,   0, 1, 8'h00, 4'b0000, 4'b0000, 0, 0};
      vecs[16] = '{1, 0, 8'h00, 4'b0000, 0, 0,   0, 1, 8'h00, 4'b0000, 4'b0000, 0, 0};

      drive(0, 0, 8'h00, 4'b0000, 0, 0);
      step();

      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].rst_n, vecs[i].v, vecs[i].res, vecs[i].st, vecs[i].rdy, vecs[i].clr);
         step();
         chk("o_valid",   i, valid_out,  vecs[i].e_v);
         chk("o_ready",   i, ready_out,  vecs[i].e_rdy);
         chk("o_result",  i, result_out, vecs[i].e_res);
         chk("o_status",  i, status_out, vecs[i].e_st);
         chk("o_sticky",  i, sticky,     vecs[i].e_sticky);
         chk("o_txn_cnt", i, txn_cnt,    vecs[i].e_cnt);
         chk("o_err_cnt", i, err_cnt,    vecs[i].e_err * EN);
      end

      // Back-to-back stream from EMPTY: one result per cycle, no stall.
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 8'(i), 4'b0000, 1, 0);
         step();
         chk("stream_ready", i, ready_out,  1);
         chk("stream_valid", i, valid_out,  1);
         chk("stream_res",   i, result_out, i);
      end
      drive(1, 0, 8'h00, 4'b0000, 1, 0);
      step();
      chk("stream_drain_valid", 0, valid_out, 0);
      chk("stream_txn_cnt",     0, txn_cnt,   10);

      // Error counter: saturation, non-error statuses, clear behaviour.
      drive(0, 0, 8'h00, 4'b0000, 1, 0);
      step();
      for (int i = 0; i < 300; i++) begin
         drive(1, 1, 8'(i), 4'b0001, 1, 0);
         step();
      end
      chk("err_sat",      0, err_cnt, 255 * EN);
      chk("err_sat_txn",  0, txn_cnt, 300);
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 8'h55, 4'b0110, 1, 0);
         step();
      end
      chk("err_hold",     0, err_cnt, 255 * EN);
      chk("err_hold_stk", 0, sticky,  4'b0111);
      drive(1, 0, 8'h00, 4'b0000, 1, 1);
      step();
      chk("err_clr",      0, err_cnt, 0);
      chk("err_clr_stk",  0, sticky,  4'b0000);
      chk("err_clr_txn",  0, txn_cnt, 303);
      drive(1, 1, 8'h77, 4'b1000, 1, 1);
      step();
      chk("err_clr_acc",  0, err_cnt, EN);
      chk("err_clr_acc_stk", 0, sticky, 4'b1000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
